// File: rtl/input_port_conditioner_pkg.sv
// input_port_conditioner_pkg: shared constants and sizing helper for the input port conditioner
package input_port_conditioner_pkg;
  localparam int PORT_W = 32;
  localparam int DEF_TICK_DIV = 50000;
  localparam int DEF_STABLE_TICKS = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r < 1 ? 1 : r;
  endfunction
endpackage

// File: rtl/input_port_conditioner_debounce_bit.sv
// input_debounce_bit: two-flop synchroniser, tick-counted debounce and edge pulses for one pin
module input_debounce_bit
  import input_port_conditioner_pkg::*;
#(
  parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic RESET_VALUE  = 1'b0
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic raw,
  input  logic tick,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic accept
);
  localparam int CNT_W = clog2(STABLE_TICKS);
  logic s1, s2;
  logic [CNT_W-1:0] cnt;
  assign accept = (s2 != debounced) && tick && (cnt == CNT_W'(STABLE_TICKS - 1));
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      s1 <= RESET_VALUE;
      s2 <= RESET_VALUE;
      debounced <= RESET_VALUE;
      cnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      rise <= accept & s2;
      fall <= accept & ~s2;
      // returning to the accepted level restarts the stability window
      if (s2 == debounced) cnt <= '0;
      else if (accept) begin
        debounced <= s2;
        cnt <= '0;
      end else if (tick) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/input_port_conditioner.sv
// input_port_conditioner: debounced, synchronised board inputs for the AHB input port word
module input_port_conditioner
  import input_port_conditioner_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               TICK_DIV     = DEF_TICK_DIV,
  parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [WIDTH-1:0]  raw_in,
  input  logic              clear_event,
  output logic [PORT_W-1:0] port_word,
  output logic [WIDTH-1:0]  rise_pulse,
  output logic [WIDTH-1:0]  fall_pulse,
  output logic              event_flag
);
  localparam int PRE_W = clog2(TICK_DIV);
  logic [PRE_W-1:0] pre;
  logic tick;
  logic [WIDTH-1:0] debounced, accept;
  assign tick = pre == PRE_W'(TICK_DIV - 1);
  assign port_word = PORT_W'(debounced);
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pre <= '0;
      event_flag <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      event_flag <= (|accept) | (event_flag & ~clear_event);
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    input_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_VALUE (RESET_VALUE[i])
    ) u_bit (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .raw      (raw_in[i]),
      .tick     (tick),
      .debounced(debounced[i]),
      .rise     (rise_pulse[i]),
      .fall     (fall_pulse[i]),
      .accept   (accept[i])
    );
  end
endmodule

// File: tb/tb_input_port_conditioner.sv
// tb_input_port_conditioner: directed checks of sync, debounce, pulses and event flag
module tb_input_port_conditioner;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic [7:0] raw_in = 8'hFF;
  logic [7:0] raw_b = 8'h00;
  logic clear_event = 1'b0;
  logic clear_b = 1'b0;
  logic [31:0] port_word, word_b;
  logic [7:0] rise_pulse, fall_pulse, rise_b, fall_b;
  logic event_flag, flag_b;
  int n_chk = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  input_port_conditioner #(.WIDTH(8), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_VALUE(8'h00)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .raw_in(raw_in), .clear_event(clear_event),
    .port_word(port_word), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .event_flag(event_flag));

  input_port_conditioner #(.WIDTH(8), .TICK_DIV(1), .STABLE_TICKS(1), .RESET_VALUE(8'h00)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .raw_in(raw_b), .clear_event(clear_b),
    .port_word(word_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .event_flag(flag_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_word(input logic [31:0] exp, input logic [7:0] er, input logic [7:0] ef,
                           input int lo, input int hi, input string tag);
    int n = 0;
    while (port_word !== exp && n < 40) begin
      step();
      n++;
      if (port_word !== exp) chk({tag, "_early_pulse"}, {24'h0, rise_pulse | fall_pulse}, 32'h0);
    end
    chk({tag, "_word"}, port_word, exp);
    chk({tag, "_latency_ok"}, {31'h0, n >= lo && n <= hi}, 32'h1);
    chk({tag, "_rise"}, {24'h0, rise_pulse}, {24'h0, er});
    chk({tag, "_fall"}, {24'h0, fall_pulse}, {24'h0, ef});
  endtask

  initial begin
    // reset with all raw pins high
    repeat (2) step();
    HRESET = 1'b0;
    chk("rst_word", port_word, 32'h0);
    chk("rst_rise", {24'h0, rise_pulse}, 32'h0);
    chk("rst_fall", {24'h0, fall_pulse}, 32'h0);
    chk("rst_flag", {31'h0, event_flag}, 32'h0);
    chk("rst_word_b", word_b, 32'h0);
    wait_word(32'hFF, 8'hFF, 8'h00, 12, 12, "rst_accept");
    chk("rst_flag_set", {31'h0, event_flag}, 32'h1);
    step();
    chk("rst_rise_end", {24'h0, rise_pulse}, 32'h0);
    raw_in = 8'h00;
    wait_word(32'h0, 8'h00, 8'hFF, 11, 14, "all_fall");
    clear_event = 1'b1;
    step();
    clear_event = 1'b0;
    chk("clr_flag", {31'h0, event_flag}, 32'h0);
    // clean single edge
    raw_in = 8'h01;
    wait_word(32'h1, 8'h01, 8'h00, 11, 14, "clean");
    chk("clean_flag", {31'h0, event_flag}, 32'h1);
    step();
    chk("clean_rise_end", {24'h0, rise_pulse}, 32'h0);
    chk("clean_hold", port_word, 32'h1);
    chk("clean_flag_hold", {31'h0, event_flag}, 32'h1);
    // bouncing bit 3 never stays long enough to be accepted
    for (int c = 0; c < 40; c++) begin
      raw_in[3] = ((c / 5) % 2) == 0;
      step();
      chk("bounce_word", port_word, 32'h1);
      chk("bounce_pulse", {24'h0, rise_pulse | fall_pulse}, 32'h0);
    end
    raw_in = 8'h09;
    wait_word(32'h9, 8'h08, 8'h00, 11, 14, "bounce_settle");
    // simultaneous multi-bit edges
    raw_in = 8'h00;
    wait_word(32'h0, 8'h00, 8'h09, 11, 14, "multi_clr");
    raw_in = 8'hA5;
    wait_word(32'hA5, 8'hA5, 8'h00, 11, 14, "multi_rise");
    step();
    chk("multi_rise_end", {24'h0, rise_pulse}, 32'h0);
    raw_in = 8'h00;
    wait_word(32'h0, 8'h00, 8'hA5, 11, 14, "multi_fall");
    step();
    chk("multi_fall_end", {24'h0, fall_pulse}, 32'h0);
    // clear held through an accepted change: set wins, then clear alone drops the flag
    clear_event = 1'b1;
    raw_in = 8'h3C;
    step();
    chk("prio_cleared", {31'h0, event_flag}, 32'h0);
    wait_word(32'h3C, 8'h3C, 8'h00, 10, 13, "prio");
    chk("prio_set_wins", {31'h0, event_flag}, 32'h1);
    step();
    chk("prio_clear_alone", {31'h0, event_flag}, 32'h0);
    clear_event = 1'b0;
    // reset part-way through a pending change
    HRESET = 1'b1;
    raw_in = 8'h00;
    step();
    chk("mid_rst_word", port_word, 32'h0);
    HRESET = 1'b0;
    raw_in = 8'h10;
    raw_b = 8'h01;
    step();
    step();
    chk("fast_before", word_b, 32'h0);
    step();
    chk("fast_accept", word_b, 32'h1);
    chk("fast_rise", {24'h0, rise_b}, 32'h1);
    step();
    chk("fast_rise_end", {24'h0, rise_b}, 32'h0);
    repeat (4) step();
    chk("mid_pending", port_word, 32'h0);
    HRESET = 1'b1;
    step();
    chk("mid_rst_word2", port_word, 32'h0);
    chk("mid_rst_pulse", {24'h0, rise_pulse | fall_pulse}, 32'h0);
    chk("mid_rst_word_b", word_b, 32'h0);
    HRESET = 1'b0;
    wait_word(32'h10, 8'h10, 8'h00, 12, 12, "mid_full_window");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
